hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline sequencer for the 5-stage core; sits beside the ID-stage control decoder.
- Detects load-use hazards, multi-cycle multiply occupancy, taken branches/jumps and halt.
- Drives the decoder's bubble select (control_sel), the PC and IF/ID write enables, the IF/ID flush and the EX freeze.
- Owns the only stall state in the core.

Parameters:
MUL_CYCLES, 4, total EX cycles of a mul (alu_sel 4'b1100); legal range 1..16; 1 means no stall.
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..4.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_inst  input  32  instruction currently in ID
id_pc_src  input  2  pc_src from the ID control decoder (00 seq, 01 branch/jal target, 11 jalr)
ex_mem_read  input  1  ID/EX instruction is a load
ex_rd  input  5  ID/EX destination register
ex_is_mul  input  1  ID/EX instruction is a mul
control_sel  output  1  1 = decoder emits a bubble into ID/EX
pc_write  output  1  PC register enable
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  IF/ID loads a NOP on the next edge
ex_stall  output  1  freeze ID/EX and EX/MEM, and hold MEM/WB write-back
halted  output  1  core is halted

Behaviour:
- Registered state: st in {RUN, LOAD_STALL, MUL_BUSY, HALTED}, cnt (4 bits), mul_done (1 bit).
- All outputs are combinational from state and inputs.
- Reset (rst_n low, asynchronous): st=RUN, cnt=0, mul_done=0.
- Outputs while in reset: control_sel=1, pc_write=0, ifid_write=0, ifid_flush=0, ex_stall=0, halted=0.
- Default outputs in RUN with no event: control_sel=0, pc_write=1, ifid_write=1, ifid_flush=0, ex_stall=0, halted=0.
- Source-register use, decoded from id_inst[6:0]:
  - rs1=id_inst[19:15] is used by all opcodes except 1101111 (jal) and 1111111 (halt).
  - rs2=id_inst[24:20] is used only by 0110011, 1100011 and 0100011.
- Event priority, highest first:
  1. HALTED state.
  2. MUL_BUSY state, or mul trigger (RUN && ex_is_mul && !mul_done).
  3. LOAD_STALL state, or load-use trigger (RUN && ex_mem_read && ex_rd!=0 && ex_rd matches a used rs).
  4. Halt opcode in ID.
  5. Taken redirect (id_pc_src != 00).
- Mul trigger:
  - Outputs: ex_stall=1, pc_write=0, ifid_write=0, control_sel=0.
  - If MUL_CYCLES==1: no stall; the trigger is ignored.
  - If MUL_CYCLES==2: stay in RUN and set mul_done.
  - Otherwise: go to MUL_BUSY with cnt=MUL_CYCLES-3.
- MUL_BUSY: same outputs as the mul trigger.
  - cnt>0: decrement cnt.
  - cnt==0: go to RUN and set mul_done.
  - Total stall is exactly MUL_CYCLES-1 cycles.
- mul_done clears after exactly one cycle in RUN, so the released mul cannot re-trigger.
- Load-use trigger:
  - Outputs: control_sel=1, pc_write=0, ifid_write=0.
  - If LOAD_USE_BUBBLES>1: go to LOAD_STALL with cnt=LOAD_USE_BUBBLES-2.
- LOAD_STALL: same outputs as load-use.
  - cnt>0: decrement cnt.
  - cnt==0: go to RUN.
  - Total bubbles are exactly LOAD_USE_BUBBLES.
- Halt opcode (7'b1111111) in ID:
  - Current cycle: pc_write=0, ifid_write=0, control_sel=0. The halt enters EX normally.
  - Next state: HALTED.
- HALTED outputs: control_sel=1, pc_write=0, ifid_write=0, ifid_flush=0, ex_stall=0, halted=1.
- HALTED is left only by reset.
- Taken redirect: ifid_flush=1 and pc_write=1 in the same cycle; 1-cycle penalty.
- Simultaneous events:
  - Load-use with a branch in ID: no flush; the branch re-evaluates after the bubble.
  - Mul stall with a branch or halt in ID: the branch/halt is held, with ifid_flush=0.
  - Mul and load-use never coexist, since EX holds one instruction; if both inputs are asserted, mul wins.
- ex_rd==0 never causes a hazard.
- Reset mid-stall (in MUL_BUSY or LOAD_STALL): the state is abandoned immediately; no pending counts survive.

Decomposition:
- Shared package (core_pkg):
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_HALT.
  - pc_src encodings: PC_SEQ, PC_TGT, PC_JALR.
  - alu_sel constant ALU_MUL.
  - hazard state enum.
- No sub-module required; the single FSM with its down-counter stays in hazard_unit.

Test Plan:
- Load-use: EX holds lw x5 (ex_mem_read=1, ex_rd=5), ID holds add x6,x5,x1 -> exactly 1 cycle with control_sel=1, pc_write=0, ifid_write=0; then ex_mem_read=0 -> RUN defaults.
- No hazard on x0 or an unused rs: ex_rd=0, and separately ex_rd=5 with ID jal -> no stall.
- Mul with MUL_CYCLES=4: ex_is_mul held high -> ex_stall=1 for exactly 3 cycles, then 1 free cycle, no re-trigger.
- Mul vs branch: ex_is_mul=1 with id_pc_src=01 -> ifid_flush=0 for the 3 stall cycles, then ifid_flush=1 for one cycle.
- Load-use vs branch: LOAD_USE_BUBBLES=2, lw x3 in EX, beq x3,x4 in ID with id_pc_src=01 -> 2 bubbles and no flush; flush only afterwards.
- Halt then reset: id_inst[6:0]=1111111 -> next cycle halted=1, pc_write=0 indefinitely; rst_n pulsed low mid-HALTED -> halted=0 immediately, RUN on release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: opcodes, pc_src encodings,
// ALU select values and the hazard sequencer state.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_TGT  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b11;

  localparam logic [3:0] ALU_MUL = 4'b1100;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_LOAD_STALL,
    HZ_MUL_BUSY,
    HZ_HALTED
  } hz_state_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return (opcode != OP_JAL) && (opcode != OP_HALT);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_BRANCH) || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Pipeline sequencer: load-use bubbles, multi-cycle mul freeze, redirect
// flush and halt. Holds the only stall state in the core.
//
//  state          | meaning
//  HZ_RUN         | normal issue; triggers evaluated from ID/EX inputs
//  HZ_LOAD_STALL  | extra load-use bubbles, cnt counts down remaining
//  HZ_MUL_BUSY    | mul occupying EX, cnt counts down remaining
//  HZ_HALTED      | halt retired into EX; left only by reset
module hazard_unit
  import core_pkg::*;
#(
  parameter int MUL_CYCLES       = 4,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_inst,
  input  logic [1:0]  id_pc_src,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_mul,
  output logic        control_sel,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        ex_stall,
  output logic        halted
);

  localparam logic [3:0] MUL_CNT_INIT  = (MUL_CYCLES >= 3) ? 4'(MUL_CYCLES - 3) : 4'd0;
  localparam logic [3:0] LOAD_CNT_INIT = (LOAD_USE_BUBBLES >= 2) ? 4'(LOAD_USE_BUBBLES - 2) : 4'd0;

  hz_state_e  st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mul_done_q, mul_done_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs_match;
  logic       mul_trig;
  logic       load_trig;
  logic       unused_inst_bits;

  assign opcode = id_inst[6:0];
  assign rs1    = id_inst[19:15];
  assign rs2    = id_inst[24:20];
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  assign rs_match  = (uses_rs1(opcode) && (ex_rd == rs1)) ||
                     (uses_rs2(opcode) && (ex_rd == rs2));
  assign mul_trig  = (MUL_CYCLES > 1) && (st_q == HZ_RUN) && ex_is_mul && !mul_done_q;
  assign load_trig = (st_q == HZ_RUN) && ex_mem_read && (ex_rd != 5'd0) && rs_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= HZ_RUN;
      cnt_q      <= 4'd0;
      mul_done_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      mul_done_q <= mul_done_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    mul_done_d  = 1'b0;
    control_sel = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    ex_stall    = 1'b0;
    halted      = 1'b0;

    if (st_q == HZ_HALTED) begin
      control_sel = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      halted      = 1'b1;
    end else if ((st_q == HZ_MUL_BUSY) || mul_trig) begin
      // Any branch/halt in ID simply waits behind the frozen mul.
      ex_stall   = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if (st_q == HZ_MUL_BUSY) begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          st_d       = HZ_RUN;
          mul_done_d = 1'b1;
        end
      end else if (MUL_CYCLES == 2) begin
        mul_done_d = 1'b1;
      end else begin
        st_d  = HZ_MUL_BUSY;
        cnt_d = MUL_CNT_INIT;
      end
    end else if ((st_q == HZ_LOAD_STALL) || load_trig) begin
      control_sel = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      if (st_q == HZ_LOAD_STALL) begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               st_d  = HZ_RUN;
      end else if (LOAD_USE_BUBBLES > 1) begin
        st_d  = HZ_LOAD_STALL;
        cnt_d = LOAD_CNT_INIT;
      end
    end else if (opcode == OP_HALT) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      st_d       = HZ_HALTED;
    end else if (id_pc_src != PC_SEQ) begin
      ifid_flush = 1'b1;
    end

    // Outputs track rst_n directly so the pipeline is quiescent during reset.
    if (!rst_n) begin
      control_sel = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      ex_stall    = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (default and MUL_CYCLES=2,
// LOAD_USE_BUBBLES=2) share directed stimulus; outputs compared at negedge.
module tb_hazard_unit;

  typedef struct {
    string      tag;
    int         dut;
    logic [5:0] exp;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_inst = 32'h0000_0013;
  logic [1:0]  id_pc_src = 2'b00;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_is_mul = 1'b0;

  logic a_cs, a_pcw, a_ifw, a_fl, a_st, a_h;
  logic b_cs, b_pcw, b_ifw, b_fl, b_st, b_h;

  sb_entry_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // {control_sel, pc_write, ifid_write, ifid_flush, ex_stall, halted}
  localparam logic [5:0] O_RST = 6'b100000;
  localparam logic [5:0] O_RUN = 6'b011000;
  localparam logic [5:0] O_LU  = 6'b100000;
  localparam logic [5:0] O_MUL = 6'b000010;
  localparam logic [5:0] O_HLT = 6'b000000;
  localparam logic [5:0] O_HD  = 6'b100001;
  localparam logic [5:0] O_RED = 6'b011100;

  localparam logic [31:0] I_NOP  = 32'h0000_0013;
  localparam logic [31:0] I_ADD  = {7'b0, 5'd1, 5'd5, 3'b0, 5'd6, 7'b0110011};
  localparam logic [31:0] I_JAL  = {7'b0, 5'd5, 5'd5, 3'b0, 5'd1, 7'b1101111};
  localparam logic [31:0] I_ADDI = {7'b0, 5'd5, 5'd2, 3'b0, 5'd7, 7'b0010011};
  localparam logic [31:0] I_RS2  = {7'b0, 5'd5, 5'd2, 3'b0, 5'd7, 7'b0110011};
  localparam logic [31:0] I_BEQ  = {7'b0, 5'd4, 5'd3, 3'b0, 5'd0, 7'b1100011};
  localparam logic [31:0] I_HALT = 32'h0000_007F;

  hazard_unit #(.MUL_CYCLES(4), .LOAD_USE_BUBBLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_pc_src(id_pc_src),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_is_mul(ex_is_mul),
    .control_sel(a_cs), .pc_write(a_pcw), .ifid_write(a_ifw),
    .ifid_flush(a_fl), .ex_stall(a_st), .halted(a_h)
  );

  hazard_unit #(.MUL_CYCLES(2), .LOAD_USE_BUBBLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_pc_src(id_pc_src),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_is_mul(ex_is_mul),
    .control_sel(b_cs), .pc_write(b_pcw), .ifid_write(b_ifw),
    .ifid_flush(b_fl), .ex_stall(b_st), .halted(b_h)
  );

  always #5 clk = ~clk;

  initial begin : monitor
    sb_entry_t  e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = (e.dut == 0) ? {a_cs, a_pcw, a_ifw, a_fl, a_st, a_h}
                           : {b_cs, b_pcw, b_ifw, b_fl, b_st, b_h};
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s dut%0d actual=%b expected=%b", e.tag, e.dut, act, e.exp);
        end
      end
    end
  end

  task automatic step(input string tag, input logic rst, input logic [31:0] inst,
                      input logic [1:0] pcs, input logic mr, input logic [4:0] rd,
                      input logic mul, input logic [5:0] ea, input logic [5:0] eb);
    sb_entry_t e;
    @(posedge clk);
    #1;
    rst_n       = rst;
    id_inst     = inst;
    id_pc_src   = pcs;
    ex_mem_read = mr;
    ex_rd       = rd;
    ex_is_mul   = mul;
    e.tag = tag; e.dut = 0; e.exp = ea; sb_q.push_back(e);
    e.tag = tag; e.dut = 1; e.exp = eb; sb_q.push_back(e);
  endtask

  initial begin : stimulus
    //    tag              rst  inst    pcs   mr  rd    mul  dut_a  dut_b
    step("reset",          0, I_NOP,  2'b00, 0, 5'd0, 0, O_RST, O_RST);
    step("run_idle",       1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("lu_trig",        1, I_ADD,  2'b00, 1, 5'd5, 0, O_LU,  O_LU);
    step("lu_release",     1, I_ADD,  2'b00, 0, 5'd5, 0, O_RUN, O_LU);
    step("lu_done",        1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("x0_no_hazard",   1, I_NOP,  2'b00, 1, 5'd0, 0, O_RUN, O_RUN);
    step("jal_unused",     1, I_JAL,  2'b00, 1, 5'd5, 0, O_RUN, O_RUN);
    step("rs2_unused",     1, I_ADDI, 2'b00, 1, 5'd5, 0, O_RUN, O_RUN);
    step("rs2_hazard",     1, I_RS2,  2'b00, 1, 5'd5, 0, O_LU,  O_LU);
    step("rs2_release",    1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_LU);
    step("rs2_done",       1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("mul_c1",         1, I_NOP,  2'b00, 0, 5'd0, 1, O_MUL, O_MUL);
    step("mul_c2",         1, I_NOP,  2'b00, 0, 5'd0, 1, O_MUL, O_RUN);
    step("mul_c3",         1, I_NOP,  2'b00, 0, 5'd0, 1, O_MUL, O_MUL);
    step("mul_free",       1, I_NOP,  2'b00, 0, 5'd0, 1, O_RUN, O_RUN);
    step("mul_after",      1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("mulbr_c1",       1, I_BEQ,  2'b01, 0, 5'd0, 1, O_MUL, O_MUL);
    step("mulbr_c2",       1, I_BEQ,  2'b01, 0, 5'd0, 1, O_MUL, O_RED);
    step("mulbr_c3",       1, I_BEQ,  2'b01, 0, 5'd0, 0, O_MUL, O_RED);
    step("mulbr_flush",    1, I_BEQ,  2'b01, 0, 5'd0, 0, O_RED, O_RED);
    step("mulbr_done",     1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("lubr_b1",        1, I_BEQ,  2'b01, 1, 5'd3, 0, O_LU,  O_LU);
    step("lubr_b2",        1, I_BEQ,  2'b01, 0, 5'd0, 0, O_RED, O_LU);
    step("lubr_flush",     1, I_BEQ,  2'b01, 0, 5'd0, 0, O_RED, O_RED);
    step("lubr_done",      1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("mul_over_lu",    1, I_ADD,  2'b00, 1, 5'd5, 1, O_MUL, O_MUL);
    step("mul_over_lu2",   1, I_NOP,  2'b00, 0, 5'd0, 0, O_MUL, O_RUN);
    step("mul_over_lu3",   1, I_NOP,  2'b00, 0, 5'd0, 0, O_MUL, O_RUN);
    step("mul_over_lu4",   1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("rst_mul_start",  1, I_NOP,  2'b00, 0, 5'd0, 1, O_MUL, O_MUL);
    step("rst_mul_mid",    0, I_NOP,  2'b00, 0, 5'd0, 0, O_RST, O_RST);
    step("rst_mul_after",  1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("rst_lu_start",   1, I_ADD,  2'b00, 1, 5'd5, 0, O_LU,  O_LU);
    step("rst_lu_mid",     0, I_NOP,  2'b00, 0, 5'd0, 0, O_RST, O_RST);
    step("rst_lu_after",   1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("halt_id",        1, I_HALT, 2'b00, 0, 5'd0, 0, O_HLT, O_HLT);
    step("halted_1",       1, I_NOP,  2'b00, 0, 5'd0, 0, O_HD,  O_HD);
    step("halted_evts",    1, I_BEQ,  2'b01, 1, 5'd3, 1, O_HD,  O_HD);
    step("halted_3",       1, I_NOP,  2'b00, 0, 5'd0, 0, O_HD,  O_HD);
    step("halt_rst",       0, I_NOP,  2'b00, 0, 5'd0, 0, O_RST, O_RST);
    step("halt_rst_run",   1, I_NOP,  2'b00, 0, 5'd0, 0, O_RUN, O_RUN);
    step("mulhalt_c1",     1, I_HALT, 2'b00, 0, 5'd0, 1, O_MUL, O_MUL);
    step("mulhalt_c2",     1, I_HALT, 2'b00, 0, 5'd0, 0, O_MUL, O_HLT);
    step("mulhalt_c3",     1, I_HALT, 2'b00, 0, 5'd0, 0, O_MUL, O_HD);
    step("mulhalt_halt",   1, I_HALT, 2'b00, 0, 5'd0, 0, O_HLT, O_HD);
    step("mulhalt_hd",     1, I_NOP,  2'b00, 0, 5'd0, 0, O_HD,  O_HD);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d expected=0 pending entries", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
